// File: rtl/cpu_step_ctrl.sv
// Run/step controller for the single-cycle MIPS core.
// Gates CPU execution with a registered clock-enable, sequences CPU reset
// pulses, counts executed cycles and muxes one debug byte onto the LEDs.
module cpu_step_ctrl #(
  parameter int DBG_CH  = 6,
  parameter int SEL_W   = 3,
  parameter int BURST_W = 8,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            MODE,
  input  logic                  GO,
  input  logic [BURST_W-1:0]    BURST_N,
  input  logic                  SOFT_RST,
  input  logic [SEL_W-1:0]      SEL,
  input  logic [1:0]            BYTE_SEL,
  input  logic [32*DBG_CH-1:0]  DBG_BUS,
  output logic                  CPU_CE,
  output logic                  CPU_RST,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      CYCLES,
  output logic [7:0]            LED
);

  // Width of the reset-sequence counter; always at least one bit.
  localparam int RC_W = $clog2(RST_CYC + 1);

  // Halt (2'b00) needs no constant: it is simply "none of the others".
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BURST,
    RSTSEQ
  } state_e;

  state_e              state_q, state_d;
  logic [BURST_W-1:0]  bcnt_q, bcnt_d;   // CE cycles still owed after the current one
  logic [RC_W-1:0]     rcnt_q, rcnt_d;   // reset cycles left, including the current one
  logic                ce_q, ce_d;
  logic                rst_q, rst_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [7:0]          led_q, led_d;
  logic                go_q, srst_q;
  logic                go_rise, srst_rise;

  logic [DBG_CH-1:0][31:0] dbg_ch;

  assign dbg_ch    = DBG_BUS;
  assign go_rise   = GO & ~go_q;
  assign srst_rise = SOFT_RST & ~srst_q;

  // Next-state and registered-output decode for the run/step FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d = state_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    ce_d    = 1'b0;
    rst_d   = 1'b0;

    if (srst_rise) begin
      // Soft reset wins everywhere, and restarts the count inside RSTSEQ.
      state_d = RSTSEQ;
      rcnt_d  = RC_W'(RST_CYC);
      rst_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MODE == MODE_RUN) begin
            state_d = RUN;
            ce_d    = 1'b1;
          end else if (go_rise && MODE == MODE_STEP) begin
            state_d = BURST;
            bcnt_d  = '0;
            ce_d    = 1'b1;
          end else if (go_rise && MODE == MODE_BURST) begin
            // The first CE cycle is issued on entry, so store N-1; a zero
            // length still spends one cycle in BURST with CE low.
            state_d = BURST;
            if (BURST_N != '0) begin
              bcnt_d = BURST_N - BURST_W'(1);
              ce_d   = 1'b1;
            end else begin
              bcnt_d = '0;
            end
          end
        end
        RUN: begin
          if (MODE == MODE_RUN) ce_d    = 1'b1;
          else                  state_d = IDLE;
        end
        BURST: begin
          // MODE is deliberately not looked at: a started burst always completes.
          if (bcnt_q != '0) begin
            bcnt_d = bcnt_q - BURST_W'(1);
            ce_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RSTSEQ: begin
          if (rcnt_q <= RC_W'(1)) begin
            state_d = IDLE;
          end else begin
            rcnt_d = rcnt_q - RC_W'(1);
            rst_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Executed-cycle counter: cleared by soft reset, otherwise counts CE cycles.
  always_comb begin
    cycles_d = cycles_q;
    if (srst_rise)  cycles_d = '0;
    else if (ce_q)  cycles_d = cycles_q + CNT_W'(1);
  end

  // Debug byte mux; channels beyond DBG_CH read as zero.
  always_comb begin
    led_d = 8'h00;
    for (int c = 0; c < DBG_CH; c++) begin
      if (SEL == SEL_W'(c)) led_d = dbg_ch[c][{BYTE_SEL, 3'b000} +: 8];
    end
  end

  // State and output registers; reset starts a full CPU reset sequence.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q  <= RSTSEQ;
      rcnt_q   <= RC_W'(RST_CYC);
      bcnt_q   <= '0;
      ce_q     <= 1'b0;
      rst_q    <= 1'b1;
      cycles_q <= '0;
      led_q    <= 8'h00;
      go_q     <= 1'b0;
      srst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      bcnt_q   <= bcnt_d;
      ce_q     <= ce_d;
      rst_q    <= rst_d;
      cycles_q <= cycles_d;
      led_q    <= led_d;
      go_q     <= GO;
      srst_q   <= SOFT_RST;
    end
  end

  assign CPU_CE  = ce_q;
  assign CPU_RST = rst_q;
  assign BUSY    = (state_q != IDLE);
  assign CYCLES  = cycles_q;
  assign LED     = led_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: expected per-edge outputs are queued
// before each clock edge and compared one time unit after it.
module tb_cpu_step_ctrl;

  localparam int DBG_CH  = 6;
  localparam int SEL_W   = 3;
  localparam int BURST_W = 8;
  localparam int CNT_W   = 4;
  localparam int RST_CYC = 4;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [1:0]           MODE;
  logic                 GO;
  logic [BURST_W-1:0]   BURST_N;
  logic                 SOFT_RST;
  logic [SEL_W-1:0]     SEL;
  logic [1:0]           BYTE_SEL;
  logic [32*DBG_CH-1:0] DBG_BUS;
  logic                 CPU_CE;
  logic                 CPU_RST;
  logic                 BUSY;
  logic [CNT_W-1:0]     CYCLES;
  logic [7:0]           LED;

  cpu_step_ctrl #(
    .DBG_CH  (DBG_CH),
    .SEL_W   (SEL_W),
    .BURST_W (BURST_W),
    .CNT_W   (CNT_W),
    .RST_CYC (RST_CYC)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .MODE     (MODE),
    .GO       (GO),
    .BURST_N  (BURST_N),
    .SOFT_RST (SOFT_RST),
    .SEL      (SEL),
    .BYTE_SEL (BYTE_SEL),
    .DBG_BUS  (DBG_BUS),
    .CPU_CE   (CPU_CE),
    .CPU_RST  (CPU_RST),
    .BUSY     (BUSY),
    .CYCLES   (CYCLES),
    .LED      (LED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string            tag;
    logic             ce;
    logic             rst;
    logic             busy;
    logic [CNT_W-1:0] cyc;
    logic [7:0]       led;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then pop and compare everything queued for it.
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".ce"},     32'(CPU_CE),  32'(e.ce));
      chk({e.tag, ".rst"},    32'(CPU_RST), 32'(e.rst));
      chk({e.tag, ".busy"},   32'(BUSY),    32'(e.busy));
      chk({e.tag, ".cycles"}, 32'(CYCLES),  32'(e.cyc));
      chk({e.tag, ".led"},    32'(LED),     32'(e.led));
    end
  endtask

  task automatic step(input string tag, input logic ce, input logic rst,
                      input logic busy, input int cyc);
    exp_t e;
    e.tag  = tag;
    e.ce   = ce;
    e.rst  = rst;
    e.busy = busy;
    e.cyc  = CNT_W'(cyc % 16);
    e.led  = 8'h00;
    sb.push_back(e);
    tick();
  endtask

  task automatic led_step(input string tag, input logic [7:0] led, input int cyc);
    exp_t e;
    e.tag  = tag;
    e.ce   = 1'b0;
    e.rst  = 1'b0;
    e.busy = 1'b0;
    e.cyc  = CNT_W'(cyc % 16);
    e.led  = led;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b1;
    MODE     = 2'b00;
    GO       = 1'b0;
    BURST_N  = '0;
    SOFT_RST = 1'b0;
    SEL      = '0;
    BYTE_SEL = 2'd0;
    DBG_BUS  = '0;
    #10;
    RST = 1'b0;

    // Reset state, then CPU_RST held for RST_CYC edges.
    chk("reset.cpu_rst", 32'(CPU_RST), 32'd1);
    chk("reset.busy",    32'(BUSY),    32'd1);
    chk("reset.ce",      32'(CPU_CE),  32'd0);
    chk("reset.cycles",  32'(CYCLES),  32'd0);
    chk("reset.led",     32'(LED),     32'd0);
    for (int i = 0; i < RST_CYC - 1; i++) step("reset_hold", 0, 1, 1, 0);
    step("reset_done", 0, 0, 0, 0);

    // Two single steps.
    MODE = 2'b10;
    GO = 1'b1; step("step1_on", 1, 0, 1, 0);
    GO = 1'b0; step("step1_off", 0, 0, 0, 1);
    step("step_gap", 0, 0, 0, 1);
    GO = 1'b1; step("step2_on", 1, 0, 1, 1);
    GO = 1'b0; step("step2_off", 0, 0, 0, 2);

    // GO held high for 10 cycles gives a single pulse.
    GO = 1'b1; step("hold_on", 1, 0, 1, 2);
    for (int i = 0; i < 9; i++) step("hold_high", 0, 0, 0, 3);
    GO = 1'b0; step("hold_release", 0, 0, 0, 3);

    // Halt ignores GO.
    MODE = 2'b00;
    GO = 1'b1; step("halt_go", 0, 0, 0, 3);
    GO = 1'b0; step("halt_idle", 0, 0, 0, 3);

    // Burst of 5; MODE change mid-burst must not cut it short.
    MODE = 2'b11; BURST_N = 8'd5;
    GO = 1'b1; step("burst5_1", 1, 0, 1, 3);
    GO = 1'b0; MODE = 2'b00;
    for (int i = 0; i < 4; i++) step("burst5_n", 1, 0, 1, 4 + i);
    step("burst5_end", 0, 0, 0, 8);
    step("burst5_idle", 0, 0, 0, 8);

    // Burst of 0: BUSY for one cycle, no CE.
    MODE = 2'b11; BURST_N = 8'd0;
    GO = 1'b1; step("burst0_busy", 0, 0, 1, 8);
    GO = 1'b0; step("burst0_end", 0, 0, 0, 8);
    step("burst0_idle", 0, 0, 0, 8);

    // Soft reset from idle clears CYCLES.
    MODE = 2'b00;
    SOFT_RST = 1'b1; step("srst_edge", 0, 1, 1, 0);
    SOFT_RST = 1'b0;
    for (int i = 0; i < RST_CYC - 1; i++) step("srst_hold", 0, 1, 1, 0);
    step("srst_done", 0, 0, 0, 0);

    // Run for 20 cycles with a 4-bit counter: wraps to 4.
    MODE = 2'b01;
    for (int i = 1; i <= 20; i++) step("run", 1, 0, 1, i - 1);
    MODE = 2'b00;
    step("run_stop", 0, 0, 0, 4);
    step("run_idle", 0, 0, 0, 4);

    // Soft reset after 3 CE cycles of a 10-cycle burst.
    MODE = 2'b11; BURST_N = 8'd10;
    GO = 1'b1; step("mb_ce1", 1, 0, 1, 4);
    GO = 1'b0; step("mb_ce2", 1, 0, 1, 5);
    step("mb_ce3", 1, 0, 1, 6);
    SOFT_RST = 1'b1; step("mb_srst", 0, 1, 1, 0);
    SOFT_RST = 1'b0;
    GO = 1'b1; step("mb_rs_go", 0, 1, 1, 0);
    GO = 1'b0; step("mb_rs2", 0, 1, 1, 0);
    step("mb_rs3", 0, 1, 1, 0);
    step("mb_idle", 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("mb_no_resume", 0, 0, 0, 0);

    // LED mux.
    MODE = 2'b00;
    DBG_BUS[0   +: 32] = 32'h11223344;
    DBG_BUS[32  +: 32] = 32'h55667788;
    DBG_BUS[64  +: 32] = 32'hA1B2C3D4;
    DBG_BUS[160 +: 32] = 32'hDEADBEEF;
    SEL = 3'd2; BYTE_SEL = 2'd3;
    chk("led_latency", 32'(LED), 32'h00);
    led_step("led_c2_b3", 8'hA1, 0);
    BYTE_SEL = 2'd0; led_step("led_c2_b0", 8'hD4, 0);
    SEL = 3'd5; BYTE_SEL = 2'd2; led_step("led_c5_b2", 8'hAD, 0);
    SEL = 3'd7; led_step("led_sel7", 8'h00, 0);
    SEL = 3'd6; led_step("led_sel6", 8'h00, 0);
    SEL = 3'd0; BYTE_SEL = 2'd1; led_step("led_c0_b1", 8'h33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Board-level run/step controller for the single-cycle MIPS core. It sits between the board clock/buttons and the CPU: it gates CPU execution with a clock-enable and sequences CPU reset pulses, so the core can free-run, single-step or execute a programmed burst of N cycles. It also counts executed cycles and muxes one byte of any of several 32-bit debug channels onto the 8 LEDs. It is the synthesizable, parametrised replacement for hand-driven clock/reset pulse sequences.

## Interface

Parameters:
- DBG_CH, 6, number of 32-bit debug channels on DBG_BUS.
- SEL_W, 3, width of SEL; DBG_CH ≤ 2^SEL_W.
- BURST_W, 8, width of BURST_N.
- CNT_W, 16, width of the CYCLES counter.
- RST_CYC, 4, CPU reset pulse length in cycles (≥1).

Ports:
- CLK, in, 1, single system clock; all logic on rising edge.
- RST, in, 1, asynchronous active-high reset.
- MODE, in, 2: 00 halt, 01 run, 10 step, 11 burst.
- GO, in, 1, start level; rising edge detected internally.
- BURST_N, in, BURST_W, burst length, latched on the GO edge.
- SOFT_RST, in, 1, CPU reset request; rising edge detected internally.
- SEL, in, SEL_W, debug channel select.
- BYTE_SEL, in, 2, byte select within channel (0 = bits 7:0).
- DBG_BUS, in, 32*DBG_CH, channel c occupies bits 32c+31:32c.
- CPU_CE, out, 1, CPU clock enable (registered).
- CPU_RST, out, 1, CPU synchronous reset (registered).
- BUSY, out, 1, high when state ≠ IDLE.
- CYCLES, out, CNT_W, count of cycles with CPU_CE=1.
- LED, out, 8, selected debug byte (registered).

## Operation

- Edge detectors: go_q and srst_q registers. go_rise = GO & ~go_q. srst_rise = SOFT_RST & ~srst_q. Both registers reset to 0.
- FSM states:
  - IDLE:
    - If MODE=01, go to RUN.
    - Else if go_rise & MODE=10, go to BURST with remaining count = 1.
    - Else if go_rise & MODE=11, go to BURST with remaining count = BURST_N.
    - MODE=00 ignores GO.
  - RUN: CPU_CE=1. If MODE≠01, go to IDLE.
  - BURST:
    - CPU_CE=1 while remaining count ≠ 0; the count decrements each cycle.
    - Go to IDLE when the count reaches 0.
    - A latched count of 0 produces zero CE cycles and returns to IDLE.
  - RSTSEQ: CPU_RST=1, CPU_CE=0 for RST_CYC cycles, then go to IDLE.
- Priority: srst_rise in any state forces RSTSEQ and clears CYCLES. In RSTSEQ it restarts the RST_CYC count.
- MODE is sampled only in IDLE and RUN. MODE changes during BURST do not affect it; the burst completes.
- GO edges outside IDLE are ignored and not queued.
- CYCLES increments on every edge where CPU_CE=1 and wraps from 2^CNT_W−1 to 0.
- LED = DBG_BUS[32·SEL + 8·BYTE_SEL +: 8]. If SEL ≥ DBG_CH, LED = 8'h00.

## Timing

- Async RST values:
  - state=RSTSEQ with count loaded to RST_CYC
  - CPU_RST=1, CPU_CE=0, BUSY=1
  - CYCLES=0, LED=0
- After RST deasserts, CPU_RST stays high for RST_CYC clock edges, then drops. IDLE is reached on the same edge.
- CPU_CE and CPU_RST are registered outputs.
- Step: at edge k, GO is sampled 1 with go_q=0. CPU_CE is high for exactly the cycle after edge k and low after edge k+1.
- Burst N: CPU_CE is high for N consecutive cycles starting after edge k. BUSY falls on the same edge CE falls.
- Run: CE rises one edge after MODE=01 is sampled in IDLE. CE falls one edge after MODE≠01 is sampled.
- SOFT_RST: on the edge sampling srst_rise, CE→0, CPU_RST→1 and CYCLES→0. CPU_RST stays high for RST_CYC cycles.
- LED latency is 1 cycle from SEL, BYTE_SEL or DBG_BUS change.
- Back-to-back steps need GO low for ≥1 sampled edge between pulses.

## Test plan

- Reset: assert RST for 10 ns, then release. Required:
  - CPU_RST=1 and BUSY=1 for 4 edges, then 0.
  - CE=0 and CYCLES=0 throughout.
- Step: MODE=10, two GO pulses. Required: two 1-cycle CE pulses and CYCLES=2; GO held high for 10 cycles yields only one pulse.
- Burst: MODE=11, BURST_N=5, GO pulse. Required:
  - exactly 5 consecutive CE cycles, CYCLES=5.
  - Repeat with BURST_N=0 → no CE, BUSY high for 1 cycle, CYCLES unchanged.
- Run and wrap: CNT_W=4, MODE=01 for 20 cycles, then MODE=00. Required: CE high for 20 cycles; CYCLES wraps to 4; CE low one edge after MODE change.
- SOFT_RST mid-burst: BURST_N=10, pulse SOFT_RST after 3 CE cycles. Required:
  - CE drops next edge, CPU_RST high 4 cycles, CYCLES=0.
  - The burst is not resumed; GO pulses during RSTSEQ are ignored.
- LED mux: channel 2 = 32'hA1B2C3D4, SEL=2, BYTE_SEL=3 → LED=8'hA1 one edge later. SEL=7 (with DBG_CH=6) → LED=8'h00.
